rsa_host_ctrl: RTL

RSA_HOST_CTRL -- requirements
Module: rsa_host_ctrl

---
 rtl/rsa_host_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/rsa_host_ctrl.sv
// RSA host controller: streams operands in as words, runs the
// modexp core, streams the result back out as words.
module rsa_host_ctrl #(
  parameter int WIDTH   = 4096,
  parameter int WORD    = 32,
  parameter int TIMEOUT = 1 << 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WORD-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WORD-1:0]  out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             timeout,
  output logic [WIDTH-1:0] core_message,
  output logic [WIDTH-1:0] core_exponent,
  output logic [WIDTH-1:0] core_modulus,
  output logic             core_go,
  output logic             core_reset,
  input  logic [WIDTH-1:0] core_cypher,
  input  logic             core_done
);

  localparam int NW = WIDTH / WORD;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST_W = CW'(NW - 1);
  localparam logic [TW-1:0] LAST_T = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_M,
    LOAD_E,
    LOAD_N,
    CLR,
    RUN,
    UNLOAD
  } state_t;

  // {in_ready, busy, core_go, core_reset, out_valid}
  function automatic logic [4:0] flags(input state_t s);
    unique case (s)
      IDLE:    flags = 5'b10000;
      LOAD_M:  flags = 5'b11000;
      LOAD_E:  flags = 5'b11000;
      LOAD_N:  flags = 5'b11000;
      CLR:     flags = 5'b01010;
      RUN:     flags = 5'b01100;
      UNLOAD:  flags = 5'b01001;
      default: flags = 5'b10000;
    endcase
  endfunction

  state_t           state;
  logic [4:0]       flg;
  logic [CW-1:0]    wcnt;
  logic             ccnt;
  logic [TW-1:0]    rcnt;
  logic [WIDTH-1:0] result;
  logic             acc;

  assign {in_ready, busy, core_go, core_reset, out_valid} = flg;
  assign out_data = result[WORD-1:0];
  assign acc      = in_valid && in_ready;

  // Main FSM: operand load, core clear, run with watchdog, unload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      flg           <= flags(IDLE);
      wcnt          <= '0;
      ccnt          <= 1'b0;
      rcnt          <= '0;
      result        <= '0;
      timeout       <= 1'b0;
      core_message  <= '0;
      core_exponent <= '0;
      core_modulus  <= '0;
    end else begin
      if (acc) timeout <= 1'b0;
      unique case (state)
        IDLE, LOAD_M: begin
          if (acc) begin
            core_message <= {in_data, core_message[WIDTH-1:WORD]};
            if (wcnt == LAST_W) begin
              wcnt  <= '0;
              state <= LOAD_E;
              flg   <= flags(LOAD_E);
            end else begin
              wcnt  <= wcnt + 1'b1;
              state <= LOAD_M;
              flg   <= flags(LOAD_M);
            end
          end
        end
        LOAD_E: begin
          if (acc) begin
            core_exponent <= {in_data, core_exponent[WIDTH-1:WORD]};
            if (wcnt == LAST_W) begin
              wcnt  <= '0;
              state <= LOAD_N;
              flg   <= flags(LOAD_N);
            end else begin
              wcnt  <= wcnt + 1'b1;
            end
          end
        end
        LOAD_N: begin
          if (acc) begin
            core_modulus <= {in_data, core_modulus[WIDTH-1:WORD]};
            if (wcnt == LAST_W) begin
              wcnt  <= '0;
              ccnt  <= 1'b0;
              state <= CLR;
              flg   <= flags(CLR);
            end else begin
              wcnt  <= wcnt + 1'b1;
            end
          end
        end
        CLR: begin
          if (ccnt) begin
            rcnt  <= '0;
            state <= RUN;
            flg   <= flags(RUN);
          end else begin
            ccnt <= 1'b1;
          end
        end
        RUN: begin
          if (core_done) begin
            result <= core_cypher;
            wcnt   <= '0;
            state  <= UNLOAD;
            flg    <= flags(UNLOAD);
          end else if (rcnt == LAST_T) begin
            timeout <= 1'b1;
            state   <= IDLE;
            flg     <= flags(IDLE);
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        UNLOAD: begin
          if (out_ready) begin
            result <= result >> WORD;
            if (wcnt == LAST_W) begin
              wcnt  <= '0;
              state <= IDLE;
              flg   <= flags(IDLE);
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          flg   <= flags(IDLE);
        end
      endcase
    end
  end

endmodule
